uart_tx_feeder: RTL and testbench

- Upstream stage of the UART transmitter.
- Pops bytes from the read-side FIFO and presents each one on the transmitter's byte/trigger interface.
- Waits for the transmitter's busy flag to complete a full frame, then inserts an inter-byte gap.
- Sole owner of the FIFO read strobe for the UART path. Detects a transmitter that never starts a frame, or never finishes one.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_feeder.sv | 134 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the feeder state encoding.
package uart_pkg;
  localparam int SCLK_HZ     = 50_000_000;
  localparam int BAUD        = 115200;
  localparam int CYC_PER_BIT = SCLK_HZ / BAUD;
  localparam int FRAME_BITS  = 10;

  // One frame is 4340 cycles; round up to the next all-ones value for margin.
  localparam int FRAME_TMO_DEF = (1 << $clog2(CYC_PER_BIT * FRAME_BITS + 1)) - 1;

  localparam int TMR_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    LAT,
    LOAD,
    TRIG,
    WAIT_BUSY,
    WAIT_DONE,
    GAP,
    ERR
  } feeder_state_e;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == {TMR_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/uart_tx_feeder.sv
// Pops bytes from the read FIFO, triggers the UART transmitter and guards it with timeouts.
// UART_TX_FEEDER_STATS_EN enables the completed-byte counter on byte_cnt.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int TRIG_HOLD  = 4,
  parameter int GAP_CYCLES = 16,
  parameter int START_TMO  = 32,
  parameter int FRAME_TMO  = FRAME_TMO_DEF
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rfifo_empty,
  output logic        rfifo_rd_en,
  input  logic [7:0]  rfifo_dout,
  output logic [7:0]  tx_data,
  output logic        tx_trig,
  input  logic        tx_busy,
  output logic        tx_done,
  output logic        err_tmo,
  input  logic        clr_err,
  output logic        idle,
  output logic [15:0] byte_cnt
);

  // Timers hold cycles already spent, so "last" is the limit minus one.
  localparam logic [TMR_W-1:0] TRIG_LAST  = TMR_W'(TRIG_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TMO - 1);
  localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(FRAME_TMO - 1);

  feeder_state_e    state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] st_tmr_q, st_tmr_d;
  logic             busy_seen_q, busy_seen_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_trig_q, tx_trig_d;
  logic             tx_done_q, tx_done_d;
  logic             err_q, err_d;
  logic             idle_q, idle_d;
  logic             in_start, busy_hit, start_exp, capture;

  always_comb begin
    state_d   = state_q;
    in_start  = (state_q == TRIG) || (state_q == WAIT_BUSY);
    busy_hit  = busy_seen_q || tx_busy;
    start_exp = (st_tmr_q == START_LAST) && !busy_hit;
    // A first-word-fall-through FIFO advances on the pop, so grab its head in RD.
    capture   = (RD_LAT == 0) ? (state_q == RD) : (state_q == LOAD);

    unique case (state_q)
      IDLE:      if (enable && !rfifo_empty && !tx_busy) state_d = RD;
      RD:        state_d = (RD_LAT != 0) ? LAT : LOAD;
      LAT:       state_d = LOAD;
      LOAD:      state_d = TRIG;
      TRIG: begin
        if (start_exp)               state_d = ERR;
        else if (tmr_q == TRIG_LAST) state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_hit)       state_d = WAIT_DONE;
        else if (start_exp) state_d = ERR;
      end
      WAIT_DONE: begin
        if (!tx_busy)                 state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (tmr_q == FRAME_LAST) state_d = ERR;
      end
      GAP:       if (tmr_q == GAP_LAST) state_d = IDLE;
      ERR:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    tmr_d       = (state_d != state_q) ? '0 : sat_inc(tmr_q);
    st_tmr_d    = (in_start && (state_d == TRIG || state_d == WAIT_BUSY)) ? sat_inc(st_tmr_q) : '0;
    busy_seen_d = in_start && busy_hit;

    tx_data_d = capture ? rfifo_dout : tx_data_q;
    tx_trig_d = (state_d == TRIG);
    tx_done_d = (state_q == WAIT_DONE) && !tx_busy;
    idle_d    = (state_d == IDLE);
    // Clear wins over a timeout landing in the same cycle.
    err_d     = clr_err ? 1'b0 : (err_q || (state_d == ERR));
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      st_tmr_q    <= '0;
      busy_seen_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_trig_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      err_q       <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      st_tmr_q    <= st_tmr_d;
      busy_seen_q <= busy_seen_d;
      tx_data_q   <= tx_data_d;
      tx_trig_q   <= tx_trig_d;
      tx_done_q   <= tx_done_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
    end
  end

  assign rfifo_rd_en = (state_q == RD);
  assign tx_data     = tx_data_q;
  assign tx_trig     = tx_trig_q;
  assign tx_done     = tx_done_q;
  assign err_tmo     = err_q;
  assign idle        = idle_q;

`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;

  // Advances with tx_done so both are visible in the same cycle.
  always_comb byte_cnt_d = tx_done_d ? byte_cnt_q + 16'd1 : byte_cnt_q;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) byte_cnt_q <= 16'h0000;
    else        byte_cnt_q <= byte_cnt_d;
  end

  assign byte_cnt = byte_cnt_q;
`else
  assign byte_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a FIFO model and a two-flop-sync transmitter model.
module tb_uart_tx_feeder;
  localparam int BUSY_LEN = 434 * 10;
  localparam int M_NORMAL = 0, M_NEVER = 1, M_STUCK = 2;
`ifdef UART_TX_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic sclk, rst_n, enable, rfifo_empty, rfifo_rd_en, tx_trig, tx_busy, tx_done, err_tmo, clr_err, idle;
  logic [7:0]  rfifo_dout, tx_data;
  logic [15:0] byte_cnt;

  uart_tx_feeder dut (
    .sclk(sclk), .reset(rst_n), .enable(enable), .rfifo_empty(rfifo_empty),
    .rfifo_rd_en(rfifo_rd_en), .rfifo_dout(rfifo_dout), .tx_data(tx_data), .tx_trig(tx_trig),
    .tx_busy(tx_busy), .tx_done(tx_done), .err_tmo(err_tmo), .clr_err(clr_err), .idle(idle),
    .byte_cnt(byte_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_tests = 0, n_fail = 0;

  // FIFO model: one cycle read latency, output holds between pops.
  logic [7:0] mem [16];
  int wr_ptr = 0, rd_ptr = 0;
  assign rfifo_empty = (wr_ptr == rd_ptr);
  initial rfifo_dout = 8'h00;
  always @(posedge sclk) begin
    if (rfifo_rd_en) begin
      rfifo_dout <= mem[rd_ptr[3:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Transmitter model: edge-detects tx_trig through two flops.
  int   mode = M_NORMAL;
  logic t1, t2;
  int   bcnt;
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= 1'b0; t2 <= 1'b0; tx_busy <= 1'b0; bcnt <= 0;
    end else begin
      t1 <= tx_trig;
      t2 <= t1;
      if (t1 && !t2 && mode != M_NEVER && !tx_busy) begin
        tx_busy <= 1'b1;
        bcnt    <= BUSY_LEN - 1;
      end else if (tx_busy && mode != M_STUCK) begin
        if (bcnt == 0) tx_busy <= 1'b0;
        else           bcnt    <= bcnt - 1;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int   cyc = 0, rd_n = 0, done_n = 0, n_log = 0, trig_len = 0, uflow = 0;
  int   trig_rise_cyc = 0, err_rise_cyc = 0, busy_fall_cyc = 0;
  int   rd_log [64];
  int   done_log [64];
  logic [7:0] data_log [64];
  logic trig_prev = 1'b0, err_prev = 1'b0, busy_prev = 1'b0;
  always @(negedge sclk) begin
    cyc++;
    if (rfifo_rd_en) begin
      rd_log[rd_n[5:0]] = cyc;
      rd_n++;
      if (rfifo_empty) uflow++;
    end
    if (tx_trig) begin
      if (!trig_prev) begin
        trig_len = 0;
        trig_rise_cyc = cyc;
        data_log[n_log[5:0]] = tx_data;
        n_log++;
      end
      trig_len++;
    end
    if (tx_done) begin
      done_log[done_n[5:0]] = cyc;
      done_n++;
    end
    if (err_tmo && !err_prev) err_rise_cyc = cyc;
    if (!tx_busy && busy_prev) busy_fall_cyc = cyc;
    trig_prev = tx_trig;
    err_prev  = err_tmo;
    busy_prev = tx_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_done(input string tag, input int base, input int max);
    int i = 0;
    while (done_n <= base && i < max) begin @(negedge sclk); i++; end
    chk(tag, 32'(done_n > base), 1);
  endtask

  task automatic wait_err(input string tag, input int max);
    int i = 0;
    while (!err_tmo && i < max) begin @(negedge sclk); i++; end
    chk(tag, 32'(err_tmo), 1);
  endtask

  int b_rd, b_done, b_log, i;

  initial begin
    rst_n = 1'b1; enable = 1'b0; clr_err = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    chk("rst_rd_en", 32'(rfifo_rd_en), 0);
    chk("rst_trig",  32'(tx_trig), 0);
    chk("rst_data",  32'(tx_data), 0);
    chk("rst_done",  32'(tx_done), 0);
    chk("rst_err",   32'(err_tmo), 0);
    chk("rst_idle",  32'(idle), 1);
    chk("rst_cnt",   32'(byte_cnt), 0);
    rst_n = 1'b1;

    // Single byte A5
    b_rd = rd_n; b_done = done_n; b_log = n_log;
    push(8'hA5); enable = 1'b1;
    wait_done("t1_wait", b_done, 6000);
    chk("t1_rd_cycles", rd_n - b_rd, 1);
    chk("t1_data",      32'(data_log[b_log[5:0]]), 32'h A5);
    chk("t1_trig_len",  trig_len, 4);
    chk("t1_done_cnt",  done_n - b_done, 1);
    // done registered one cycle after busy is seen low
    chk("t1_done_lag",  done_log[b_done[5:0]] - busy_fall_cyc, 1);

    // Three queued bytes after a fresh reset
    @(negedge sclk); rst_n = 1'b0; @(negedge sclk); rst_n = 1'b1;
    b_rd = rd_n; b_done = done_n; b_log = n_log;
    push(8'h01); push(8'h02); push(8'h03);
    wait_done("t2_wait", b_done + 2, 20000);
    chk("t2_rd_cycles", rd_n - b_rd, 3);
    chk("t2_data0", 32'(data_log[b_log[5:0]]), 32'h01);
    chk("t2_data1", 32'(data_log[6'(b_log + 1)]), 32'h02);
    chk("t2_data2", 32'(data_log[6'(b_log + 2)]), 32'h03);
    chk("t2_cnt",   32'(byte_cnt), STATS ? 3 : 0);
    // 16 GAP cycles (first carries tx_done) + 1 IDLE, pop on the next
    chk("t2_gap0", rd_log[6'(b_rd + 1)] - done_log[b_done[5:0]], 17);
    chk("t2_gap1", rd_log[6'(b_rd + 2)] - done_log[6'(b_done + 1)], 17);
    chk("t2_fifo", wr_ptr - rd_ptr, 0);

    // Transmitter never starts
    mode = M_NEVER; b_done = done_n;
    push(8'h3C);
    wait_err("t3_err_wait", 200);
    @(negedge sclk);
    chk("t3_start_tmo", err_rise_cyc - trig_rise_cyc, 32);
    chk("t3_idle",      32'(idle), 1);
    chk("t3_no_done",   done_n - b_done, 0);
    clr_err = 1'b1; @(negedge sclk); clr_err = 1'b0;
    chk("t3_clr", 32'(err_tmo), 0);
    mode = M_NORMAL; b_log = n_log; b_done = done_n;
    push(8'h5A);
    wait_done("t3_next_wait", b_done, 6000);
    chk("t3_next_data", 32'(data_log[b_log[5:0]]), 32'h5A);
    chk("t3_next_err",  32'(err_tmo), 0);

    // Busy stuck high: frame timeout, then stale busy blocks the next pop
    mode = M_STUCK; b_done = done_n; b_rd = rd_n;
    push(8'h77); push(8'h88);
    wait_err("t4_err_wait", 9000);
    @(negedge sclk);
    // 4 TRIG + 1 WAIT_BUSY cycle, then 8191 cycles in WAIT_DONE
    chk("t4_frame_tmo", err_rise_cyc - trig_rise_cyc, 8196);
    chk("t4_no_done",   done_n - b_done, 0);
    repeat (50) @(negedge sclk);
    chk("t4_blocked_rd", rd_n - b_rd, 1);
    chk("t4_blocked_idle", 32'(idle), 1);
    clr_err = 1'b1; @(negedge sclk); clr_err = 1'b0;
    mode = M_NORMAL; b_log = n_log;
    wait_done("t4_next_wait", b_done, 12000);
    chk("t4_next_data", 32'(data_log[b_log[5:0]]), 32'h88);
    chk("t4_next_done", done_n - b_done, 1);
    chk("t4_cnt", 32'(byte_cnt), STATS ? 5 : 0);

    // enable dropped mid-frame with two bytes queued
    b_done = done_n; b_rd = rd_n; b_log = n_log;
    push(8'h11); push(8'h22);
    i = 0;
    while (!tx_busy && i < 100) begin @(negedge sclk); i++; end
    chk("t5_busy_wait", 32'(tx_busy), 1);
    repeat (10) @(negedge sclk);
    enable = 1'b0;
    wait_done("t5_wait", b_done, 6000);
    repeat (40) @(negedge sclk);
    chk("t5_idle",  32'(idle), 1);
    chk("t5_rd_en", 32'(rfifo_rd_en), 0);
    chk("t5_rd_cycles", rd_n - b_rd, 1);
    chk("t5_fifo",  wr_ptr - rd_ptr, 1);
    chk("t5_data",  32'(data_log[b_log[5:0]]), 32'h11);

    // Reset during TRIG: 22 is dropped, 33 goes out afterwards
    push(8'h33); enable = 1'b1; b_log = n_log;
    i = 0;
    while (!tx_trig && i < 100) begin @(negedge sclk); i++; end
    chk("t6_trig_wait", 32'(tx_trig), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_trig", 32'(tx_trig), 0);
    chk("t6_async_idle", 32'(idle), 1);
    @(negedge sclk); rst_n = 1'b1;
    b_done = done_n;
    wait_done("t6_wait", b_done, 6000);
    chk("t6_logged", n_log - b_log, 2);
    chk("t6_data",   32'(data_log[6'(n_log - 1)]), 32'h33);
    chk("t6_cnt",    32'(byte_cnt), STATS ? 1 : 0);
    chk("t6_fifo",   wr_ptr - rd_ptr, 0);
    chk("uflow",     uflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
